voice_pool_mixer: RTL and testbench
===================================

Name: voice_pool_mixer

Overview:
- Parametrised successor to the fixed two-voice key/mix arrangement in the piano top level.
- Turns a NUM_KEYS-wide key-press vector into allocations over a pool of NUM_VOICES karplus_note voices.
- Allocation uses lowest-free-first, with oldest-voice stealing when the pool is full.
- On each codec sample request it time-multiplexes the voice samples through one accumulator and drives a scaled, saturated mono sample to WM8731_CODEC.

Parameters:
- NUM_KEYS, 17, width of press vector.
- NUM_VOICES, 4, voice pool size (>=2).
- SAMPLE_W, 16, signed voice/mix sample width.
- GAIN_SHIFT, 2, arithmetic right shift applied to the accumulated sum.
- AGE_W, 4, width of per-voice saturating age counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous active-low reset.
- press  in  NUM_KEYS  level key-down vector, already synchronous to clk.
- sample_req  in  1  one-cycle pulse: codec wants a new sample.
- voice_sample  in  NUM_VOICES*SAMPLE_W  packed signed outputs of voices; voice i at bits [i*SAMPLE_W +: SAMPLE_W].
- voice_note  out  NUM_VOICES*KEY_W  key index held by each voice; KEY_W = clog2(NUM_KEYS).
- voice_trigger  out  NUM_VOICES  one-cycle pluck pulse to voice i.
- voice_active  out  NUM_VOICES  voice i currently holds a pressed key.
- mix_out  out  SAMPLE_W  signed mixed sample, held until next update.
- mix_valid  out  1  one-cycle strobe when mix_out updates.
- busy  out  1  mixer FSM not IDLE.

Behaviour:
- Reset (reset=0, async) clears all of the following:
  - press_q, pending, voice_active, voice_note, voice_trigger, ages, mix_out, mix_valid, busy.
  - FSM returns to IDLE.
- Edge detect: press_q <= press each cycle.
  - rise = press & ~press_q is ORed into pending[NUM_KEYS].
  - fall = ~press & press_q.
- Allocation:
  - At most one key is serviced per cycle: the lowest-index set bit of pending. Its pending bit clears in that cycle.
  - If an active voice already holds that key, it is retriggered: voice_trigger pulses and its age resets to 0.
  - Else, if a voice is free, the lowest-index free voice is used.
  - Else, the oldest voice is stolen: maximum age, ties broken by lowest index.
  - The chosen voice gets voice_note=key, voice_active=1, age=0, and voice_trigger=1 for exactly the next cycle.
  - Every allocation increments the age of all other active voices, saturating at 2^AGE_W-1.
- Release:
  - fall on a key clears voice_active of the voice holding it. voice_note is retained so the string decays naturally.
  - If rise and a pending service for the same key coincide with fall, the fall wins and the pending bit is cleared.
- Mixer FSM:
  - IDLE: on sample_req, go to ACC; acc<=0, idx<=0.
  - ACC: acc += sign-extended voice_sample[idx]. All voices are summed, active or not, so decay tails are preserved. idx++. After idx=NUM_VOICES-1, go to SCALE.
  - SCALE: s = acc >>> GAIN_SHIFT, saturated to [-2^(SAMPLE_W-1), 2^(SAMPLE_W-1)-1]. mix_out<=s, mix_valid=1 for one cycle, then go to IDLE.
  - ACC_W = SAMPLE_W + clog2(NUM_VOICES) + 1. No intermediate overflow is possible.
  - Latency: sample_req to mix_valid = NUM_VOICES+2 cycles.
  - sample_req while busy=1 is ignored; no queueing.
- Allocation and mixing run independently and concurrently.

Decomposition:
- Package voice_pool_pkg holds:
  - Constants: KEY_W, ACC_W, SAT_MAX, SAT_MIN.
  - Typedef mix_state_t {IDLE, ACC, SCALE}.
  - Function sat_shift(acc) returning SAMPLE_W.
- Sub-module voice_allocator holds edge detect, pending, ages and voice state.
- The top holds the mixer FSM and instantiates voice_allocator.

Test Plan:
- Pool fill: press keys 1, 2, 3, 4 on separate cycles -> voices 0..3 active; voice_note = 1, 2, 3, 4; four single trigger pulses.
- Simultaneous press: press keys 3 and 1 in the same cycle -> key 1 goes to voice 0 in cycle N+1 and key 3 to voice 1 in cycle N+2.
- Steal: with the pool full (keys 1..4, pressed in order), press key 9 -> voice 0 (oldest) gets note 9 and a trigger; the others are untouched.
- Retrigger and release:
  - Press key 2, release it, then press it again while voice 1 still holds note 2 inactive -> free lowest voice is reused.
  - Press key 2 while it is active -> same voice retriggers.
- Mix arithmetic, samples {1000, 2000, -500, 300}, GAIN_SHIFT=2 -> mix_out = 700 exactly 6 cycles after sample_req.
- Saturation and reset:
  - All samples 32767 with GAIN_SHIFT=0 -> mix_out = 32767.
  - All samples -32768 -> mix_out = -32768.
  - Asserting reset mid-ACC -> busy=0 and mix_out=0 immediately.
  - A sample_req during busy produces no extra mix_valid.

Source files
------------

// File: rtl/voice_pool_pkg.sv
// Shared types, widths and the scale/saturate helper for the voice pool mixer.
package voice_pool_pkg;

  localparam int DEF_NUM_KEYS   = 17;
  localparam int DEF_NUM_VOICES = 4;
  localparam int DEF_SAMPLE_W   = 16;

  // Key index width and accumulator width for the default configuration.
  localparam int KEY_W = $clog2(DEF_NUM_KEYS);
  localparam int ACC_W = DEF_SAMPLE_W + $clog2(DEF_NUM_VOICES) + 1;

  // Output range expressed at accumulator width so comparisons stay signed.
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W-DEF_SAMPLE_W+1){1'b0}}, {(DEF_SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W-DEF_SAMPLE_W+1){1'b1}}, {(DEF_SAMPLE_W-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2
  } mix_state_t;

  // Arithmetic right shift of the accumulated sum, clamped to the sample range.
  function automatic logic signed [DEF_SAMPLE_W-1:0] sat_shift(
    input logic signed [ACC_W-1:0] acc,
    input int unsigned             shift
  );
    logic signed [ACC_W-1:0] sh;
    sh = acc >>> shift;
    if (sh > SAT_MAX) begin
      return SAT_MAX[DEF_SAMPLE_W-1:0];
    end else if (sh < SAT_MIN) begin
      return SAT_MIN[DEF_SAMPLE_W-1:0];
    end else begin
      return sh[DEF_SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/voice_pool_mixer_voice_allocator.sv
// Key edge detection, pending-press queue and voice pool allocation.
// One pending key is serviced per cycle (lowest index first); a key already
// sounding on an active voice retriggers it, otherwise the lowest free voice
// is used, otherwise the oldest voice is stolen.
module voice_allocator
  import voice_pool_pkg::*;
#(
  parameter int NUM_KEYS   = DEF_NUM_KEYS,
  parameter int NUM_VOICES = DEF_NUM_VOICES,
  parameter int AGE_W      = 4,
  localparam int KEY_BITS  = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_KEYS-1:0]            press,
  output logic [NUM_VOICES*KEY_BITS-1:0] voice_note,
  output logic [NUM_VOICES-1:0]          voice_trigger,
  output logic [NUM_VOICES-1:0]          voice_active
);

  localparam int VIDX_W = $clog2(NUM_VOICES);
  localparam logic [AGE_W-1:0] AGE_MAX = {AGE_W{1'b1}};

  logic [NUM_KEYS-1:0]   press_q_r;
  logic [NUM_KEYS-1:0]   pending_r, pending_next_s;
  logic [NUM_VOICES-1:0] active_r, active_next_s;
  logic [NUM_VOICES-1:0] trig_r, trig_next_s;
  logic [KEY_BITS-1:0]   note_r      [NUM_VOICES];
  logic [KEY_BITS-1:0]   note_next_s [NUM_VOICES];
  logic [AGE_W-1:0]      age_r       [NUM_VOICES];
  logic [AGE_W-1:0]      age_next_s  [NUM_VOICES];

  logic [NUM_KEYS-1:0]   rise_s, fall_s;
  logic                  svc_valid_s, do_alloc_s;
  logic [KEY_BITS-1:0]   svc_key_s;
  logic                  hit_valid_s, free_valid_s;
  logic [VIDX_W-1:0]     hit_idx_s, free_idx_s, old_idx_s, chosen_s;
  logic [AGE_W-1:0]      old_age_s;

  assign rise_s = press & ~press_q_r;
  assign fall_s = ~press & press_q_r;

  // Pick the lowest-index pending key; a release in the same cycle cancels it.
  always_comb begin
    svc_valid_s = 1'b0;
    svc_key_s   = {KEY_BITS{1'b0}};
    for (int k = NUM_KEYS-1; k >= 0; k--) begin
      if (pending_r[k]) begin
        svc_valid_s = 1'b1;
        svc_key_s   = KEY_BITS'(k);
      end else begin
        svc_key_s   = svc_key_s;
      end
    end
    do_alloc_s = svc_valid_s && !fall_s[svc_key_s];
  end

  // Candidate voices: matching active voice, lowest free voice, oldest voice.
  always_comb begin
    hit_valid_s  = 1'b0;
    hit_idx_s    = {VIDX_W{1'b0}};
    free_valid_s = 1'b0;
    free_idx_s   = {VIDX_W{1'b0}};
    for (int i = NUM_VOICES-1; i >= 0; i--) begin
      if (active_r[i] && (note_r[i] == svc_key_s)) begin
        hit_valid_s = 1'b1;
        hit_idx_s   = VIDX_W'(i);
      end else begin
        hit_idx_s   = hit_idx_s;
      end
      if (!active_r[i]) begin
        free_valid_s = 1'b1;
        free_idx_s   = VIDX_W'(i);
      end else begin
        free_idx_s   = free_idx_s;
      end
    end
    // Strict comparison keeps the lowest index on equal ages.
    old_idx_s = {VIDX_W{1'b0}};
    old_age_s = age_r[0];
    for (int i = 1; i < NUM_VOICES; i++) begin
      if (age_r[i] > old_age_s) begin
        old_age_s = age_r[i];
        old_idx_s = VIDX_W'(i);
      end else begin
        old_age_s = old_age_s;
      end
    end
    if (hit_valid_s) begin
      chosen_s = hit_idx_s;
    end else if (free_valid_s) begin
      chosen_s = free_idx_s;
    end else begin
      chosen_s = old_idx_s;
    end
  end

  // Next voice state: releases first, then the allocation overrides its voice.
  always_comb begin
    pending_next_s = (pending_r & ~fall_s) | rise_s;
    if (svc_valid_s) begin
      pending_next_s[svc_key_s] = 1'b0;
    end else begin
      pending_next_s = pending_next_s;
    end
    trig_next_s = {NUM_VOICES{1'b0}};
    for (int i = 0; i < NUM_VOICES; i++) begin
      note_next_s[i]   = note_r[i];
      age_next_s[i]    = age_r[i];
      active_next_s[i] = active_r[i] && !fall_s[note_r[i]];
      if (do_alloc_s) begin
        if (VIDX_W'(i) == chosen_s) begin
          note_next_s[i]   = svc_key_s;
          active_next_s[i] = 1'b1;
          age_next_s[i]    = {AGE_W{1'b0}};
          trig_next_s[i]   = 1'b1;
        end else if (active_r[i] && (age_r[i] != AGE_MAX)) begin
          age_next_s[i]    = age_r[i] + AGE_W'(1);
        end else begin
          age_next_s[i]    = age_r[i];
        end
      end else begin
        age_next_s[i] = age_r[i];
      end
    end
  end

  // Register key history, pending presses and per-voice state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      press_q_r <= {NUM_KEYS{1'b0}};
      pending_r <= {NUM_KEYS{1'b0}};
      active_r  <= {NUM_VOICES{1'b0}};
      trig_r    <= {NUM_VOICES{1'b0}};
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= {KEY_BITS{1'b0}};
        age_r[i]  <= {AGE_W{1'b0}};
      end
    end else begin
      press_q_r <= press;
      pending_r <= pending_next_s;
      active_r  <= active_next_s;
      trig_r    <= trig_next_s;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= note_next_s[i];
        age_r[i]  <= age_next_s[i];
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_note
    assign voice_note[g*KEY_BITS +: KEY_BITS] = note_r[g];
  end

  assign voice_trigger = trig_r;
  assign voice_active  = active_r;

endmodule

// File: rtl/voice_pool_mixer.sv
// Voice pool top: allocator for key presses plus a sequential mixer that sums
// all voice samples through one accumulator on each codec sample request.
module voice_pool_mixer
  import voice_pool_pkg::*;
#(
  parameter int          NUM_KEYS   = DEF_NUM_KEYS,
  parameter int          NUM_VOICES = DEF_NUM_VOICES,
  parameter int          SAMPLE_W   = DEF_SAMPLE_W,
  parameter int unsigned GAIN_SHIFT = 32'd2,
  parameter int          AGE_W      = 4,
  localparam int         KEY_BITS   = (NUM_KEYS > 1) ? $clog2(NUM_KEYS) : 1
)(
  input  logic                           clk,
  input  logic                           reset,
  input  logic [NUM_KEYS-1:0]            press,
  input  logic                           sample_req,
  input  logic [NUM_VOICES*SAMPLE_W-1:0] voice_sample,
  output logic [NUM_VOICES*KEY_BITS-1:0] voice_note,
  output logic [NUM_VOICES-1:0]          voice_trigger,
  output logic [NUM_VOICES-1:0]          voice_active,
  output logic [SAMPLE_W-1:0]            mix_out,
  output logic                           mix_valid,
  output logic                           busy
);

  localparam int IDX_W    = $clog2(NUM_VOICES);
  localparam int ACC_BITS = SAMPLE_W + $clog2(NUM_VOICES) + 1;

  mix_state_t                  state_r, state_next_s;
  logic signed [ACC_BITS-1:0]  acc_r, acc_next_s;
  logic [IDX_W-1:0]            idx_r, idx_next_s;
  logic signed [SAMPLE_W-1:0]  mix_out_r, mix_out_next_s;
  logic signed [SAMPLE_W-1:0]  cur_sample_s, scaled_s;
  logic                        mix_valid_r, mix_valid_next_s;
  logic                        busy_r, busy_next_s;

  voice_allocator #(
    .NUM_KEYS   (NUM_KEYS),
    .NUM_VOICES (NUM_VOICES),
    .AGE_W      (AGE_W)
  ) u_alloc (
    .clk           (clk),
    .reset         (reset),
    .press         (press),
    .voice_note    (voice_note),
    .voice_trigger (voice_trigger),
    .voice_active  (voice_active)
  );

  assign cur_sample_s = voice_sample[idx_r*SAMPLE_W +: SAMPLE_W];
  assign scaled_s     = SAMPLE_W'(sat_shift(ACC_W'(acc_r), GAIN_SHIFT));

  // Mixer next state: clear on request, accumulate every voice, then scale.
  always_comb begin
    state_next_s     = state_r;
    acc_next_s       = acc_r;
    idx_next_s       = idx_r;
    mix_out_next_s   = mix_out_r;
    mix_valid_next_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (sample_req) begin
          state_next_s = ACC;
          acc_next_s   = {ACC_BITS{1'b0}};
          idx_next_s   = {IDX_W{1'b0}};
        end else begin
          state_next_s = IDLE;
        end
      end
      ACC: begin
        // Inactive voices are summed too so release tails keep sounding.
        acc_next_s = acc_r + ACC_BITS'(cur_sample_s);
        if (idx_r == IDX_W'(NUM_VOICES-1)) begin
          state_next_s = SCALE;
          idx_next_s   = {IDX_W{1'b0}};
        end else begin
          idx_next_s   = idx_r + IDX_W'(1);
        end
      end
      SCALE: begin
        mix_out_next_s   = scaled_s;
        mix_valid_next_s = 1'b1;
        state_next_s     = IDLE;
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
    busy_next_s = (state_next_s != IDLE);
  end

  // Mixer state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Mixer datapath and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_r       <= {ACC_BITS{1'b0}};
      idx_r       <= {IDX_W{1'b0}};
      mix_out_r   <= {SAMPLE_W{1'b0}};
      mix_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      acc_r       <= acc_next_s;
      idx_r       <= idx_next_s;
      mix_out_r   <= mix_out_next_s;
      mix_valid_r <= mix_valid_next_s;
      busy_r      <= busy_next_s;
    end
  end

  assign mix_out   = mix_out_r;
  assign mix_valid = mix_valid_r;
  assign busy      = busy_r;

endmodule

// File: tb/tb_voice_pool_mixer.sv
// Self-checking bench for voice_pool_mixer: allocation scenarios plus a
// scoreboard of expected mix results for a GAIN_SHIFT=2 and a GAIN_SHIFT=0 DUT.
module tb_voice_pool_mixer;

  localparam int NK = 17;
  localparam int NV = 4;
  localparam int SW = 16;
  localparam int KW = 5;

  logic              clk = 1'b0;
  logic              reset;
  logic              sample_req;
  logic [NK-1:0]     press;
  logic [NV*SW-1:0]  vs;

  logic [NV*KW-1:0]  voice_note, voice_note0;
  logic [NV-1:0]     voice_trigger, voice_trigger0;
  logic [NV-1:0]     voice_active, voice_active0;
  logic [SW-1:0]     mix_out, mix_out0;
  logic              mix_valid, mix_valid0;
  logic              busy, busy0;

  int tests_run    = 0;
  int tests_failed = 0;
  int q2[$];
  int q0[$];

  voice_pool_mixer #(.GAIN_SHIFT(2)) dut (
    .clk(clk), .reset(reset), .press(press), .sample_req(sample_req),
    .voice_sample(vs), .voice_note(voice_note), .voice_trigger(voice_trigger),
    .voice_active(voice_active), .mix_out(mix_out), .mix_valid(mix_valid),
    .busy(busy)
  );

  voice_pool_mixer #(.GAIN_SHIFT(0)) dut0 (
    .clk(clk), .reset(reset), .press(press), .sample_req(sample_req),
    .voice_sample(vs), .voice_note(voice_note0), .voice_trigger(voice_trigger0),
    .voice_active(voice_active0), .mix_out(mix_out0), .mix_valid(mix_valid0),
    .busy(busy0)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference mix: signed sum, arithmetic shift, clamp to 16-bit range.
  function automatic int model_mix(input logic [NV*SW-1:0] v, input int shift);
    longint s;
    s = 0;
    for (int i = 0; i < NV; i++) s += longint'($signed(v[i*SW +: SW]));
    s = s >>> shift;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return int'(s);
  endfunction

  function automatic int note_of(input int i);
    return int'(voice_note[i*KW +: KW]);
  endfunction

  task automatic apply_reset();
    reset = 1'b0; press = '0; sample_req = 1'b0; vs = '0;
    @(negedge clk); @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic set_samples(input int a, input int b, input int c, input int d);
    vs = {16'(d), 16'(c), 16'(b), 16'(a)};
  endtask

  task automatic test_reset();
    reset = 1'b0; press = '0; sample_req = 1'b0; vs = '0;
    #1;
    tests_run++;
    if ({voice_active, voice_trigger, voice_note, mix_out, mix_valid, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: active=%b trig=%b note=%h mix=%0d valid=%b busy=%b required all zero",
               voice_active, voice_trigger, voice_note, $signed(mix_out), mix_valid, busy);
    end
    apply_reset();
  endtask

  task automatic test_pool_fill();
    for (int k = 1; k <= 4; k++) begin
      press[k] = 1'b1;
      @(negedge clk);
      tests_run++;
      if (voice_trigger !== 4'b0000) begin
        tests_failed++;
        $display("FAIL fill_early_trig key%0d: got %b required 0000", k, voice_trigger);
      end
      @(negedge clk);
      tests_run++;
      if (voice_trigger !== 4'(1 << (k-1)) || voice_active !== 4'((1 << k) - 1)) begin
        tests_failed++;
        $display("FAIL fill_alloc key%0d: trig=%b active=%b required %b %b", k, voice_trigger,
                 voice_active, 4'(1 << (k-1)), 4'((1 << k) - 1));
      end
      @(negedge clk);
      tests_run++;
      if (voice_trigger !== 4'b0000) begin
        tests_failed++;
        $display("FAIL fill_trig_width key%0d: got %b required 0000", k, voice_trigger);
      end
    end
    tests_run++;
    if (voice_note !== {5'd4, 5'd3, 5'd2, 5'd1}) begin
      tests_failed++;
      $display("FAIL fill_notes: got %h required %h", voice_note, {5'd4, 5'd3, 5'd2, 5'd1});
    end
  endtask

  task automatic test_steal();
    press[9] = 1'b1;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (voice_trigger !== 4'b0001 || voice_active !== 4'b1111 ||
        voice_note !== {5'd4, 5'd3, 5'd2, 5'd9}) begin
      tests_failed++;
      $display("FAIL steal_oldest: trig=%b active=%b note=%h required 0001 1111 %h",
               voice_trigger, voice_active, voice_note, {5'd4, 5'd3, 5'd2, 5'd9});
    end
    press[10] = 1'b1;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (voice_trigger !== 4'b0010 || note_of(1) != 10) begin
      tests_failed++;
      $display("FAIL steal_next: trig=%b note1=%0d required 0010 10", voice_trigger, note_of(1));
    end
    press = '0;
    @(negedge clk);
    tests_run++;
    if (voice_active !== 4'b0000 || voice_note !== {5'd4, 5'd3, 5'd10, 5'd9}) begin
      tests_failed++;
      $display("FAIL release_all: active=%b note=%h required 0000 %h", voice_active, voice_note,
               {5'd4, 5'd3, 5'd10, 5'd9});
    end
  endtask

  task automatic test_simultaneous();
    apply_reset();
    press[3] = 1'b1; press[1] = 1'b1;
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (voice_trigger !== 4'b0001 || voice_active !== 4'b0001 || note_of(0) != 1) begin
      tests_failed++;
      $display("FAIL simul_first: trig=%b active=%b note0=%0d required 0001 0001 1",
               voice_trigger, voice_active, note_of(0));
    end
    @(negedge clk);
    tests_run++;
    if (voice_trigger !== 4'b0010 || voice_active !== 4'b0011 || note_of(1) != 3) begin
      tests_failed++;
      $display("FAIL simul_second: trig=%b active=%b note1=%0d required 0010 0011 3",
               voice_trigger, voice_active, note_of(1));
    end
  endtask

  task automatic test_retrigger_release();
    apply_reset();
    press[1] = 1'b1; @(negedge clk); @(negedge clk);
    press[2] = 1'b1; @(negedge clk); @(negedge clk);
    press[2] = 1'b0; @(negedge clk);
    tests_run++;
    if (voice_active !== 4'b0001 || note_of(1) != 2) begin
      tests_failed++;
      $display("FAIL release_keep_note: active=%b note1=%0d required 0001 2", voice_active, note_of(1));
    end
    press[2] = 1'b1; @(negedge clk); @(negedge clk);
    tests_run++;
    if (voice_active !== 4'b0011 || voice_trigger !== 4'b0010 || note_of(1) != 2) begin
      tests_failed++;
      $display("FAIL repress_reuse: active=%b trig=%b note1=%0d required 0011 0010 2",
               voice_active, voice_trigger, note_of(1));
    end
    // Key 6 waits behind key 0 and is released on its service cycle.
    press[0] = 1'b1; press[6] = 1'b1;
    @(negedge clk); @(negedge clk);
    press[6] = 1'b0;
    @(negedge clk);
    tests_run++;
    if (voice_trigger !== 4'b0000 || voice_active !== 4'b0111 || note_of(2) != 0) begin
      tests_failed++;
      $display("FAIL fall_wins: trig=%b active=%b note2=%0d required 0000 0111 0",
               voice_trigger, voice_active, note_of(2));
    end
    @(negedge clk); @(negedge clk);
    tests_run++;
    if (voice_trigger !== 4'b0000 || voice_active !== 4'b0111) begin
      tests_failed++;
      $display("FAIL fall_no_late_alloc: trig=%b active=%b required 0000 0111",
               voice_trigger, voice_active);
    end
    press = '0;
    @(negedge clk);
  endtask

  // One mix request; dup_at>0 re-asserts sample_req in that cycle while busy.
  task automatic run_mix(input string name, input int dup_at);
    int c_first;
    int nvalid;
    int exp_v;
    c_first = -1;
    nvalid  = 0;
    q2.push_back(model_mix(vs, 2));
    q0.push_back(model_mix(vs, 0));
    sample_req = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      sample_req = (c == dup_at);
      if (c == 1) begin
        tests_run++;
        if (busy !== 1'b1) begin
          tests_failed++;
          $display("FAIL %s_busy_set: got %b required 1", name, busy);
        end
      end
      if (mix_valid === 1'b1) begin
        nvalid++;
        if (c_first < 0) c_first = c;
        tests_run++;
        if (q2.size() == 0) begin
          tests_failed++;
          $display("FAIL %s_extra_valid: got mix_valid with empty scoreboard", name);
        end else begin
          exp_v = q2.pop_front();
          if (int'($signed(mix_out)) !== exp_v) begin
            tests_failed++;
            $display("FAIL %s_mix_g2: got %0d required %0d", name, $signed(mix_out), exp_v);
          end
        end
      end
      if (mix_valid0 === 1'b1) begin
        tests_run++;
        if (q0.size() == 0) begin
          tests_failed++;
          $display("FAIL %s_extra_valid_g0: got mix_valid with empty scoreboard", name);
        end else begin
          exp_v = q0.pop_front();
          if (int'($signed(mix_out0)) !== exp_v) begin
            tests_failed++;
            $display("FAIL %s_mix_g0: got %0d required %0d", name, $signed(mix_out0), exp_v);
          end
        end
      end
    end
    tests_run++;
    if (c_first != 6 || nvalid != 1) begin
      tests_failed++;
      $display("FAIL %s_latency: first valid at cycle %0d, %0d strobes; required cycle 6, 1 strobe",
               name, c_first, nvalid);
    end
    tests_run++;
    if (q2.size() != 0 || q0.size() != 0) begin
      tests_failed++;
      $display("FAIL %s_timeout: %0d/%0d results never produced, required 0", name, q2.size(), q0.size());
      q2.delete(); q0.delete();
    end
  endtask

  task automatic test_mix_arith();
    set_samples(1000, 2000, -500, 300);  run_mix("arith", 0);
    set_samples(-1, 0, 0, -2);           run_mix("neg_round", 0);
  endtask

  task automatic test_saturation();
    set_samples(32767, 32767, 32767, 32767);     run_mix("sat_pos", 0);
    set_samples(-32768, -32768, -32768, -32768); run_mix("sat_neg", 0);
  endtask

  task automatic test_busy_ignore();
    set_samples(100, 200, 300, 400);
    run_mix("busy_ignore", 3);
  endtask

  task automatic test_reset_mid_acc();
    int nvalid;
    nvalid = 0;
    set_samples(1000, 2000, -500, 300);
    sample_req = 1'b1;
    @(negedge clk);
    sample_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    tests_run++;
    if (busy !== 1'b0 || mix_out !== 16'd0 || busy0 !== 1'b0 || mix_out0 !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_mid_acc: busy=%b mix=%0d busy0=%b mix0=%0d required 0 0 0 0",
               busy, $signed(mix_out), busy0, $signed(mix_out0));
    end
    @(negedge clk);
    reset = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (mix_valid === 1'b1) nvalid++;
    end
    tests_run++;
    if (nvalid != 0) begin
      tests_failed++;
      $display("FAIL reset_abort: got %0d strobes after reset, required 0", nvalid);
    end
  endtask

  initial begin
    test_reset();
    test_pool_fill();
    test_steal();
    test_simultaneous();
    test_retrigger_release();
    test_mix_arith();
    test_saturation();
    test_busy_ignore();
    test_reset_mid_acc();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
